stream_concat_fifo_n: RTL and testbench

//  Joins NUM_STREAMS independent, equal-width input streams into one wide output beat. Each lane is

---
 rtl/stream_concat_fifo_n_pkg.sv | 17 +
 rtl/stream_concat_fifo_n_if.sv | 30 +++
 rtl/stream_concat_fifo_n_lane.sv | 79 +++++++
 rtl/stream_concat_fifo_n.sv | 128 ++++++++++++
 tb/tb_stream_concat_fifo_n.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_concat_fifo_n_pkg.sv
// Shared helpers for the stream concatenation FIFO: lane entry sizing and
// the enabled-lane tlast disagreement test.
package stream_concat_fifo_n_pkg;

  localparam int MAX_STREAMS = 16;

  // A lane entry is the payload plus its tlast bit.
  function automatic int lane_entry_width(input int data_w);
    return data_w + 1;
  endfunction

  function automatic logic last_mismatch(input logic [MAX_STREAMS-1:0] en,
                                         input logic [MAX_STREAMS-1:0] last);
    return (|(en & last)) && (|(en & ~last));
  endfunction

endpackage

// File: rtl/stream_concat_fifo_n_if.sv
// Handshake bundle between the lane producers, the concatenator and the pixel writer.
interface stream_concat_fifo_n_if #(
  parameter int NUM_STREAMS  = 4,
  parameter int STREAM_WIDTH = 8
);
  logic [NUM_STREAMS-1:0]              s_stream_tenable;
  logic [NUM_STREAMS-1:0]              s_stream_tvalid;
  logic [NUM_STREAMS*STREAM_WIDTH-1:0] s_stream_tdata;
  logic [NUM_STREAMS-1:0]              s_stream_tlast;
  logic [NUM_STREAMS-1:0]              s_stream_tready;
  logic                                m_stream_tvalid;
  logic [NUM_STREAMS*STREAM_WIDTH-1:0] m_stream_tdata;
  logic                                m_stream_tlast;
  logic [NUM_STREAMS-1:0]              m_stream_tuser;
  logic                                m_stream_tready;

  modport master (
    output s_stream_tenable, s_stream_tvalid, s_stream_tdata, s_stream_tlast,
    input  s_stream_tready,
    input  m_stream_tvalid, m_stream_tdata, m_stream_tlast, m_stream_tuser,
    output m_stream_tready
  );

  modport slave (
    input  s_stream_tenable, s_stream_tvalid, s_stream_tdata, s_stream_tlast,
    output s_stream_tready,
    output m_stream_tvalid, m_stream_tdata, m_stream_tlast, m_stream_tuser,
    input  m_stream_tready
  );
endinterface

// File: rtl/stream_concat_fifo_n_lane.sv
// One input lane: a 2^D entry FIFO of {tlast, tdata} with an asynchronous head,
// or a pure pass-through when D is 0.
module stream_concat_lane
  import stream_concat_fifo_n_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 5
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         flush,
  input  logic         s_tvalid,
  input  logic [W-1:0] s_tdata,
  input  logic         s_tlast,
  output logic         s_tready,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_last,
  output logic         empty
);

  generate
    if (D == 0) begin : g_bypass
      // Without storage the producer is only accepted when the beat is consumed.
      logic unused_bypass;
      assign unused_bypass = ^{aclk, reset, flush};
      assign s_tready  = pop;
      assign head_data = s_tdata;
      assign head_last = s_tlast;
      assign empty     = !s_tvalid;
    end else begin : g_fifo
      localparam int DEPTH = 1 << D;
      localparam int EW    = lane_entry_width(W);
      localparam logic [D:0] PTR_ONE = {{D{1'b0}}, 1'b1};

      logic [EW-1:0] mem_q [DEPTH];
      logic [D:0]    wr_ptr_q, wr_ptr_d;
      logic [D:0]    rd_ptr_q, rd_ptr_d;
      logic          full_q, full_d;
      logic          wr_en;

      assign s_tready = !full_q && !reset;
      assign wr_en    = s_tvalid && s_tready && !flush;
      assign empty    = (wr_ptr_q == rd_ptr_q);
      assign {head_last, head_data} = mem_q[rd_ptr_q[D-1:0]];

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else begin
          if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (pop && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        // Full is computed from next-state pointers so tready is a clean flop.
        full_d = (wr_ptr_d[D-1:0] == rd_ptr_d[D-1:0]) && (wr_ptr_d[D] != rd_ptr_d[D]);
      end

      always_ff @(posedge aclk) begin
        if (reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          full_q   <= 1'b0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          full_q   <= full_d;
        end
      end

      always_ff @(posedge aclk) begin
        if (wr_en) mem_q[wr_ptr_q[D-1:0]] <= {s_tlast, s_tdata};
      end
    end
  endgenerate

endmodule

// File: rtl/stream_concat_fifo_n.sv
// Joins NUM_STREAMS buffered lanes into one wide beat once every enabled lane
// has data; disabled lanes read as zero and are left untouched.
module stream_concat_fifo_n
  import stream_concat_fifo_n_pkg::*;
#(
  parameter int NUM_STREAMS     = 4,
  parameter int STREAM_WIDTH    = 8,
  parameter int FIFO_DEPTH_POW2 = 5,
  parameter int OPT_REG_OUTPUT  = 0
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  flush,
  stream_concat_fifo_n_if.slave bus,
  output logic                  err_tlast_mismatch
);

  localparam int N  = NUM_STREAMS;
  localparam int W  = STREAM_WIDTH;
  localparam int BW = N * W;

  logic [N-1:0]  en;
  logic [N-1:0]  lane_empty, lane_last, lane_ok, lane_pop, lane_ready;
  logic [BW-1:0] lane_head, beat_data;
  logic          avail, stage_ready, pop, beat_last, beat_mm;
  logic          err_q, err_d;

  assign en = bus.s_stream_tenable;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      stream_concat_lane #(
        .W (W),
        .D (FIFO_DEPTH_POW2)
      ) u_lane (
        .aclk      (aclk),
        .reset     (reset),
        .flush     (flush),
        .s_tvalid  (bus.s_stream_tvalid[gi]),
        .s_tdata   (bus.s_stream_tdata[gi*W +: W]),
        .s_tlast   (bus.s_stream_tlast[gi]),
        .s_tready  (lane_ready[gi]),
        .pop       (lane_pop[gi]),
        .head_data (lane_head[gi*W +: W]),
        .head_last (lane_last[gi]),
        .empty     (lane_empty[gi])
      );
      assign lane_ok[gi]            = !en[gi] || !lane_empty[gi];
      assign lane_pop[gi]           = pop && en[gi];
      assign beat_data[gi*W +: W]   = en[gi] ? lane_head[gi*W +: W] : '0;
    end
  endgenerate

  assign bus.s_stream_tready = lane_ready;

  // An all-disabled mask never completes, so no empty beats are produced.
  assign avail     = (&lane_ok) && (|en);
  assign pop       = avail && stage_ready && !reset && !flush;
  assign beat_last = |(en & lane_last);
  assign beat_mm   = last_mismatch(MAX_STREAMS'(en), MAX_STREAMS'(lane_last));

  always_comb begin
    err_d = pop && beat_mm;
  end

  always_ff @(posedge aclk) begin
    if (reset || flush) err_q <= 1'b0;
    else                err_q <= err_d;
  end

  assign err_tlast_mismatch = err_q;

  generate
    if (OPT_REG_OUTPUT == 0) begin : g_comb_out
      assign stage_ready         = bus.m_stream_tready;
      assign bus.m_stream_tvalid = avail && !reset && !flush;
      assign bus.m_stream_tdata  = beat_data;
      assign bus.m_stream_tlast  = beat_last;
      assign bus.m_stream_tuser  = en;
    end else begin : g_reg_out
      logic          out_valid_q, out_valid_d;
      logic [BW-1:0] out_data_q, out_data_d;
      logic          out_last_q, out_last_d;
      logic [N-1:0]  out_user_q, out_user_d;

      // Loading whenever the register is empty or being drained keeps 1 beat/cycle.
      assign stage_ready = !out_valid_q || bus.m_stream_tready;

      always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        if (flush) begin
          out_valid_d = 1'b0;
        end else if (pop) begin
          out_valid_d = 1'b1;
          out_data_d  = beat_data;
          out_last_d  = beat_last;
          out_user_d  = en;
        end else if (bus.m_stream_tready) begin
          out_valid_d = 1'b0;
        end
      end

      always_ff @(posedge aclk) begin
        if (reset) begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          out_last_q  <= 1'b0;
          out_user_q  <= '0;
        end else begin
          out_valid_q <= out_valid_d;
          out_data_q  <= out_data_d;
          out_last_q  <= out_last_d;
          out_user_q  <= out_user_d;
        end
      end

      assign bus.m_stream_tvalid = out_valid_q && !reset && !flush;
      assign bus.m_stream_tdata  = out_data_q;
      assign bus.m_stream_tlast  = out_last_q;
      assign bus.m_stream_tuser  = out_user_q;
    end
  endgenerate

endmodule

// File: tb/tb_stream_concat_fifo_n.sv
// Bench for stream_concat_fifo_n: three instances (D=2 comb out, D=2 registered out,
// bypass) share one randomized stimulus; a queue scoreboard checks every delivered beat.
module tb_stream_concat_fifo_n;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  user;
    logic        mm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  tenable = 4'hF;
  logic [3:0]  tvalid = 4'hF;
  logic [31:0] tdata = 32'h0;
  logic [3:0]  tlast = 4'h0;
  logic        m_ready = 1'b1;

  logic [3:0]  rdy_v   [3];
  logic        mval_v  [3];
  logic [31:0] mdata_v [3];
  logic        mlast_v [3];
  logic [3:0]  muser_v [3];
  logic        err_v   [3];

  int checks = 0;
  int errors = 0;

  exp_t       exp_q  [2][$];
  logic [8:0] lane_q [8][$];
  int         err_seen [2];
  int         mm_cnt   [2];
  logic       err_due0 = 1'b0;
  logic       hold_v = 1'b0;
  logic [36:0] hold_beat = '0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      stream_concat_fifo_n_if #(.NUM_STREAMS(N), .STREAM_WIDTH(W)) bus ();
      assign bus.s_stream_tenable = tenable;
      assign bus.s_stream_tvalid  = tvalid;
      assign bus.s_stream_tdata   = tdata;
      assign bus.s_stream_tlast   = tlast;
      assign bus.m_stream_tready  = m_ready;
      assign rdy_v[gi]   = bus.s_stream_tready;
      assign mval_v[gi]  = bus.m_stream_tvalid;
      assign mdata_v[gi] = bus.m_stream_tdata;
      assign mlast_v[gi] = bus.m_stream_tlast;
      assign muser_v[gi] = bus.m_stream_tuser;

      stream_concat_fifo_n #(
        .NUM_STREAMS     (N),
        .STREAM_WIDTH    (W),
        .FIFO_DEPTH_POW2 (gi == 2 ? 0 : 2),
        .OPT_REG_OUTPUT  (gi == 1 ? 1 : 0)
      ) u_dut (
        .aclk               (clk),
        .reset              (reset),
        .flush              (flush),
        .bus                (bus),
        .err_tlast_mismatch (err_v[gi])
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mask_data(input logic [31:0] d, input logic [3:0] en);
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) if (en[i]) r[i*W +: W] = d[i*W +: W];
    return r;
  endfunction

  // Monitor and reference model: sampled on the falling edge, inputs are stable until the next rise.
  always @(negedge clk) begin
    exp_t        e;
    logic [3:0]  en;
    logic        av, hs, ok, any1, any0;
    logic [8:0]  v;

    en = tenable;
    // Pass-through lanes: a beat exists exactly while every enabled producer is valid.
    av = (&(~en | tvalid)) && (|en) && !reset && !flush;
    chk("bypass_handshake", 64'({rdy_v[2], mval_v[2]}), 64'({(av && m_ready) ? en : 4'h0, av}));
    if (av)
      chk("bypass_beat", 64'({mdata_v[2], mlast_v[2], muser_v[2]}),
          64'({mask_data(tdata, en), |(en & tlast), en}));

    for (int d = 0; d < 2; d++) begin
      if (d == 0) chk("err_timing", 64'(err_v[0]), 64'(err_due0));
      if (d == 1 && hold_v && !reset && !flush)
        chk("hold_stable", 64'({mval_v[1], mdata_v[1], mlast_v[1], muser_v[1]}), 64'({1'b1, hold_beat}));
      if (err_v[d]) err_seen[d]++;

      hs = mval_v[d] && m_ready;
      if (d == 0) err_due0 = 1'b0;
      if (hs) begin
        chk("beat_expected", 64'(exp_q[d].size() != 0), 64'(1));
        if (exp_q[d].size() != 0) begin
          e = exp_q[d].pop_front();
          chk(d == 0 ? "beat0" : "beat1", 64'({mdata_v[d], mlast_v[d], muser_v[d]}),
              64'({e.data, e.last, e.user}));
          if (e.mm) mm_cnt[d]++;
          if (d == 0) err_due0 = e.mm;
        end
      end
      if (d == 1) begin
        hold_v    = mval_v[1] && !m_ready && !reset && !flush;
        hold_beat = {mdata_v[1], mlast_v[1], muser_v[1]};
      end

      if (reset || flush) begin
        for (int i = 0; i < N; i++) lane_q[d*N+i].delete();
        exp_q[d].delete();
      end else begin
        for (int i = 0; i < N; i++)
          if (tvalid[i] && rdy_v[d][i]) lane_q[d*N+i].push_back({tlast[i], tdata[i*W +: W]});
        // A beat exists as soon as every enabled lane has a pending word.
        for (int k = 0; k < 8; k++) begin
          ok = (en != 4'h0);
          for (int i = 0; i < N; i++) if (en[i] && lane_q[d*N+i].size() == 0) ok = 1'b0;
          if (ok) begin
            e = '0;
            e.user = en;
            any1 = 1'b0;
            any0 = 1'b0;
            for (int i = 0; i < N; i++) begin
              if (en[i]) begin
                v = lane_q[d*N+i].pop_front();
                e.data[i*W +: W] = v[7:0];
                if (v[8]) any1 = 1'b1; else any0 = 1'b1;
              end
            end
            e.last = any1;
            e.mm   = any1 && any0;
            exp_q[d].push_back(e);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] mask;

    // Reset with every producer asserting valid.
    tdata = 32'hDEADBEEF;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk("reset_tready", 64'(rdy_v[d]), 64'(0));
        chk("reset_tvalid", 64'(mval_v[d]), 64'(0));
      end
    end
    tick();
    reset = 1'b0;
    tvalid = 4'h0;
    @(negedge clk);
    chk("post_reset_ready0", 64'(rdy_v[0]), 64'(4'hF));
    chk("post_reset_ready1", 64'(rdy_v[1]), 64'(4'hF));
    chk("post_reset_valid0", 64'(mval_v[0]), 64'(0));
    chk("post_reset_valid1", 64'(mval_v[1]), 64'(0));
    tick();

    // Skewed arrival: lanes complete on cycle 7.
    tdata = 32'h44332211;
    for (int c = 0; c < 10; c++) begin
      tvalid = 4'h0;
      case (c)
        0: tvalid = 4'b0001;
        2: tvalid = 4'b0010;
        5: tvalid = 4'b0100;
        7: tvalid = 4'b1000;
        default: tvalid = 4'h0;
      endcase
      @(negedge clk);
      if (c == 7) chk("skew_not_early", 64'(mval_v[0]), 64'(0));
      if (c == 8) begin
        chk("skew_comb", 64'({mval_v[0], mdata_v[0]}), 64'({1'b1, 32'h44332211}));
        chk("skew_reg_not_early", 64'(mval_v[1]), 64'(0));
      end
      if (c == 9) chk("skew_reg", 64'({mval_v[1], mdata_v[1]}), 64'({1'b1, 32'h44332211}));
      tick();
    end

    // Enable mask: lanes 1 and 3 hold data while only 0 and 2 are enabled.
    tvalid = 4'b1010; tdata = 32'hC3005A00;
    @(negedge clk); tick();
    tenable = 4'b0101; tvalid = 4'b0101; tdata = 32'h00BB00AA;
    @(negedge clk); tick();
    tvalid = 4'h0;
    @(negedge clk);
    chk("mask_beat", 64'({mval_v[0], mdata_v[0], muser_v[0]}), 64'({1'b1, 32'h00BB00AA, 4'b0101}));
    tick();
    @(negedge clk); tick();
    tenable = 4'hF; tvalid = 4'b0101; tdata = 32'h00020001;
    @(negedge clk); tick();
    tvalid = 4'h0;
    @(negedge clk);
    chk("mask_kept", 64'({mval_v[0], mdata_v[0], muser_v[0]}), 64'({1'b1, 32'hC3025A01, 4'hF}));
    tick();
    @(negedge clk); tick();

    // Backpressure on depth-4 lanes.
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tvalid = 4'hF;
      tdata = {4{8'(k + 8'h60)}};
      @(negedge clk);
      chk(k < 4 ? "full_ready" : "full_ready_drop", 64'(rdy_v[0]), 64'(k < 4 ? 4'hF : 4'h0));
      tick();
    end
    tvalid = 4'h0;
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("drain_valid", 64'(mval_v[0]), 64'(k < 4));
      tick();
    end

    // Mismatched tlast on two enabled lanes.
    tenable = 4'b0011; tvalid = 4'b0011; tlast = 4'b0001; tdata = 32'h00007766;
    @(negedge clk); tick();
    tvalid = 4'h0; tlast = 4'h0;
    @(negedge clk);
    chk("tlast_or", 64'({mval_v[0], mlast_v[0], err_v[0]}), 64'({1'b1, 1'b1, 1'b0}));
    tick();
    @(negedge clk);
    chk("err_pulse", 64'(err_v[0]), 64'(1));
    tick();
    @(negedge clk);
    chk("err_one_cycle", 64'(err_v[0]), 64'(0));
    tick();

    // Flush with queued beats and a concurrent write.
    tenable = 4'hF; m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tvalid = 4'hF; tdata = $urandom;
      @(negedge clk); tick();
    end
    flush = 1'b1; tdata = 32'hFFFFFFFF;
    @(negedge clk); tick();
    flush = 1'b0; tvalid = 4'h0;
    @(negedge clk);
    chk("flush_empty", 64'({mval_v[0], mval_v[1], rdy_v[0], rdy_v[1]}), 64'({1'b0, 1'b0, 4'hF, 4'hF}));
    tick();
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_dropped", 64'({mval_v[0], mval_v[1]}), 64'(0));
      tick();
    end

    // All lanes disabled never completes a beat.
    tenable = 4'h0; tvalid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_empty_beat", 64'({mval_v[0], mval_v[1], mval_v[2]}), 64'(0));
      tick();
    end

    // Randomized phases, one enable mask per phase.
    for (int ph = 0; ph < 6; ph++) begin
      tvalid = 4'h0; flush = 1'b1;
      @(negedge clk); tick();
      flush = 1'b0;
      err_seen[0] = 0; err_seen[1] = 0; mm_cnt[0] = 0; mm_cnt[1] = 0;
      mask = (ph == 0) ? 4'hF : 4'($urandom_range(1, 15));
      tenable = mask;
      for (int c = 0; c < 300; c++) begin
        tvalid = 4'($urandom);
        tdata = $urandom;
        for (int i = 0; i < N; i++) tlast[i] = ($urandom_range(0, 3) == 0);
        m_ready = ($urandom_range(0, 99) < 70);
        @(negedge clk); tick();
      end
      tvalid = 4'h0; tlast = 4'h0; m_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk); tick();
      end
      chk("phase_drained0", 64'(exp_q[0].size()), 64'(0));
      chk("phase_drained1", 64'(exp_q[1].size()), 64'(0));
      chk("phase_err_count0", 64'(err_seen[0]), 64'(mm_cnt[0]));
      chk("phase_err_count1", 64'(err_seen[1]), 64'(mm_cnt[1]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
